seq_mult: RTL and testbench



---
 rtl/seq_mult.sv | 127 ++++++++++++
 tb/tb_seq_mult.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult.sv
// Sequential unsigned shift-and-add multiplier, N x N -> 2N bits, one partial product per clock.
// A single ripple adder (fulladd4) forms each partial sum; the accumulator shifts right once per step.

module fulladd4 #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         c_in,
   output logic [N-1:0] sum,
   output logic         c_out
);

   logic [N:0] carry;

   assign carry[0] = c_in;

   for (genvar i = 0; i < N; i++) begin : g_bit
      assign sum[i]       = a[i] ^ b[i] ^ carry[i];
      assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
   end

   assign c_out = carry[N];

endmodule

module seq_mult #(
   parameter int unsigned N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product
);

   typedef enum logic [0:0] {
      StIdle,
      StRun
   } state_e;

   state_e         state_q, state_d;
   logic [N-1:0]   mcand_q, mcand_d;
   logic [2*N-1:0] acc_q, acc_d;
   logic [6:0]     cnt_q, cnt_d;
   logic [2*N-1:0] product_q, product_d;
   logic           done_q, done_d;

   logic [N-1:0]   add_b;
   logic [N-1:0]   add_sum;
   logic           add_cout;
   logic [2*N-1:0] acc_shift;
   logic           last_iter;

   // Partial product is either the multiplicand or zero, selected by the current multiplier LSB.
   assign add_b = acc_q[0] ? mcand_q : '0;

   fulladd4 #(
      .N(N)
   ) u_adder (
      .a    (acc_q[2*N-1:N]),
      .b    (add_b),
      .c_in (1'b0),
      .sum  (add_sum),
      .c_out(add_cout)
   );

   // Carry re-enters at the top as the accumulator shifts right by one.
   assign acc_shift = {add_cout, add_sum, acc_q[N-1:1]};
   assign last_iter = (cnt_q == 7'(N - 1));

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      done_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               mcand_d = a;
               acc_d   = {{N{1'b0}}, b};
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            acc_d = acc_shift;
            cnt_d = cnt_q + 7'd1;
            if (last_iter) begin
               product_d = acc_shift;
               done_d    = 1'b1;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         mcand_q   <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         done_q    <= done_d;
      end
   end

   assign busy    = (state_q == StRun);
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult: vector table plus hand-written corner sequences, with a product/latency
// scoreboard checked on every done pulse.

module tb_seq_mult;

   localparam int unsigned N = 8;

   typedef struct {
      logic [N-1:0]   a;
      logic [N-1:0]   b;
      logic [2*N-1:0] exp;
   } vec_t;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [N-1:0]   a_in;
   logic [N-1:0]   b_in;
   logic           busy;
   logic           done;
   logic [2*N-1:0] product;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [2*N-1:0] exp_q[$];
   int             cyc_q[$];

   seq_mult #(
      .N(N)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a_in),
      .b      (b_in),
      .busy   (busy),
      .done   (done),
      .product(product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Advance to the next falling edge and retire a scoreboard entry if done is high.
   task automatic tick();
      logic [2*N-1:0] e;
      int             c0;
      @(negedge clk);
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done: got done=1 expected no pending op (cycle %0d)", cyc);
         end else begin
            e  = exp_q.pop_front();
            c0 = cyc_q.pop_front();
            chk("product", 64'(product), 64'(e));
            chk("latency", 64'(cyc - c0), 64'(N));
         end
      end
   endtask

   task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv,
                         input logic [2*N-1:0] exp, input int glitch);
      tick();
      start = 1'b1;
      a_in  = av;
      b_in  = bv;
      tick();
      exp_q.push_back(exp);
      cyc_q.push_back(cyc);
      start = 1'b0;
      a_in  = N'($urandom);
      b_in  = N'($urandom);
      for (int i = 0; i < int'(N); i++) begin
         if (i > 0) tick();
         chk("busy_run", 64'(busy), 64'(1));
         chk("done_run", 64'(done), 64'(0));
         if (i == glitch) begin
            start = 1'b1;
            a_in  = 8'd9;
            b_in  = 8'd9;
         end else if (i == glitch + 1) begin
            start = 1'b0;
         end
      end
      tick();
      chk("busy_done", 64'(busy), 64'(0));
      chk("done_pulse", 64'(done), 64'(1));
      tick();
      chk("done_clear", 64'(done), 64'(0));
      chk("product_held", 64'(product), 64'(exp));
   endtask

   vec_t vecs[7];
   int   first_done;

   initial begin
      vecs[0] = '{a: 8'd13,  b: 8'd11,  exp: 16'd143};
      vecs[1] = '{a: 8'd255, b: 8'd255, exp: 16'd65025};
      vecs[2] = '{a: 8'd255, b: 8'd1,   exp: 16'd255};
      vecs[3] = '{a: 8'd128, b: 8'd128, exp: 16'd16384};
      vecs[4] = '{a: 8'd0,   b: 8'd200, exp: 16'd0};
      vecs[5] = '{a: 8'd77,  b: 8'd0,   exp: 16'd0};
      vecs[6] = '{a: 8'd1,   b: 8'd1,   exp: 16'd1};

      rst_n = 1'b0;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      #3;
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_done", 64'(done), 64'(0));
      chk("reset_product", 64'(product), 64'(0));
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].exp, -1);

      // Start pulsed mid-run must not disturb the operation.
      run_op(8'd6, 8'd7, 16'd42, 1);

      // Asynchronous reset aborts a running operation.
      tick();
      start = 1'b1;
      a_in  = 8'd100;
      b_in  = 8'd3;
      tick();
      start = 1'b0;
      chk("abort_busy_pre", 64'(busy), 64'(1));
      repeat (4) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_done", 64'(done), 64'(0));
      chk("abort_product", 64'(product), 64'(0));
      tick();
      tick();
      rst_n = 1'b1;
      repeat (12) tick();
      chk("abort_no_done", 64'(done), 64'(0));
      chk("abort_idle", 64'(busy), 64'(0));
      run_op(8'd5, 8'd5, 16'd25, -1);

      // Back-to-back: start held, second operands presented in the done cycle.
      tick();
      start = 1'b1;
      a_in  = 8'd10;
      b_in  = 8'd10;
      tick();
      exp_q.push_back(16'd100);
      cyc_q.push_back(cyc);
      for (int i = 0; i < int'(N); i++) begin
         if (i > 0) tick();
         chk("b2b_busy1", 64'(busy), 64'(1));
      end
      tick();
      chk("b2b_done1", 64'(done), 64'(1));
      first_done = cyc;
      a_in = 8'd20;
      b_in = 8'd20;
      tick();
      exp_q.push_back(16'd400);
      cyc_q.push_back(cyc);
      start = 1'b0;
      chk("b2b_busy2", 64'(busy), 64'(1));
      for (int i = 1; i < int'(N); i++) begin
         tick();
         chk("b2b_hold", 64'(product), 64'(100));
         chk("b2b_done_low", 64'(done), 64'(0));
      end
      tick();
      chk("b2b_done2", 64'(done), 64'(1));
      chk("b2b_spacing", 64'(cyc - first_done), 64'(N + 1));
      tick();
      chk("b2b_final", 64'(product), 64'(400));

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL pending_ops: got %0d outstanding expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
